// File: rtl/vproc_pkg.sv
// rtl/vproc_pkg.sv - shared vector-register constants and mask type
package vproc_pkg;

  localparam int unsigned VREG_CNT = 32;

  typedef logic [VREG_CNT-1:0] vreg_mask_t;

endpackage

// File: rtl/vproc_sb_entry.sv
// rtl/vproc_sb_entry.sv - one scoreboard slot: valid bit plus write/read reservation masks
module vproc_sb_entry
  import vproc_pkg::*;
#(
  parameter bit DONT_CARE_ZERO = 1'b0
) (
  input  logic       clk_i,
  input  logic       async_rst_ni,
  input  logic       set_i,
  input  vreg_mask_t set_wr_mask_i,
  input  vreg_mask_t set_rd_mask_i,
  input  logic       wr_clr_i,
  input  vreg_mask_t wr_clr_mask_i,
  input  logic       rd_clr_i,
  input  vreg_mask_t rd_clr_mask_i,
  input  logic       done_i,
  output logic       valid_o,
  output vreg_mask_t wr_mask_o,
  output vreg_mask_t rd_mask_o
);

  logic       valid_q, valid_d;
  vreg_mask_t wr_mask_q, wr_mask_d;
  vreg_mask_t rd_mask_q, rd_mask_d;

  // Next state: done frees the slot and beats any clear; set only reaches a free slot,
  // and clears only reach an occupied one, so set and clear never overlap.
  always_comb begin
    valid_d   = valid_q;
    wr_mask_d = wr_mask_q;
    rd_mask_d = rd_mask_q;
    if (done_i) begin
      valid_d   = 1'b0;
      wr_mask_d = '0;
      rd_mask_d = '0;
    end else if (set_i) begin
      valid_d   = 1'b1;
      wr_mask_d = set_wr_mask_i;
      rd_mask_d = set_rd_mask_i;
    end else begin
      if (wr_clr_i) wr_mask_d = wr_mask_q & ~wr_clr_mask_i;
      if (rd_clr_i) rd_mask_d = rd_mask_q & ~rd_clr_mask_i;
    end
  end

  // Slot state registers; reset drops every reservation at once.
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      valid_q   <= 1'b0;
      wr_mask_q <= '0;
      rd_mask_q <= '0;
    end else begin
      valid_q   <= valid_d;
      wr_mask_q <= wr_mask_d;
      rd_mask_q <= rd_mask_d;
    end
  end

  // A free slot always holds zero masks; the explicit gate just makes that visible downstream.
  assign valid_o   = valid_q;
  assign wr_mask_o = (DONT_CARE_ZERO && !valid_q) ? '0 : wr_mask_q;
  assign rd_mask_o = (DONT_CARE_ZERO && !valid_q) ? '0 : rd_mask_q;

endmodule

// File: rtl/vproc_vreg_scoreboard.sv
// rtl/vproc_vreg_scoreboard.sv - in-flight vector register scoreboard gating dispatch on RAW/WAW/WAR
module vproc_vreg_scoreboard
  import vproc_pkg::*;
#(
  parameter int unsigned ID_W           = 3,
  parameter bit          DONT_CARE_ZERO = 1'b0
) (
  input  logic            clk_i,
  input  logic            async_rst_ni,
  input  logic            disp_valid_i,
  output logic            disp_ready_o,
  input  vreg_mask_t      disp_wr_mask_i,
  input  vreg_mask_t      disp_rd_mask_i,
  output logic [ID_W-1:0] disp_id_o,
  input  logic            wr_clr_valid_i,
  input  logic [ID_W-1:0] wr_clr_id_i,
  input  vreg_mask_t      wr_clr_mask_i,
  input  logic            rd_clr_valid_i,
  input  logic [ID_W-1:0] rd_clr_id_i,
  input  vreg_mask_t      rd_clr_mask_i,
  input  logic            done_valid_i,
  input  logic [ID_W-1:0] done_id_i,
  output vreg_mask_t      pending_wr_o,
  output vreg_mask_t      pending_rd_o,
  output logic            busy_o,
  output logic            err_o
);

  localparam int unsigned NUM_ENT = 2 ** ID_W;

  logic [ID_W-1:0]    tail_q, tail_d;
  logic               err_q, err_d;
  logic [NUM_ENT-1:0] ent_valid;
  vreg_mask_t         ent_wr [NUM_ENT];
  vreg_mask_t         ent_rd [NUM_ENT];
  vreg_mask_t         pend_wr, pend_rd;
  logic               full, hazard, accept;
  logic               wr_clr_hit, rd_clr_hit, done_hit;

  // Release events only count against occupied slots; an accept in the same cycle
  // targets a slot that is still free, so it is treated as invalid.
  assign wr_clr_hit = wr_clr_valid_i & ent_valid[wr_clr_id_i];
  assign rd_clr_hit = rd_clr_valid_i & ent_valid[rd_clr_id_i];
  assign done_hit   = done_valid_i & ent_valid[done_id_i];

  for (genvar i = 0; i < NUM_ENT; i++) begin : g_ent
    vproc_sb_entry #(
      .DONT_CARE_ZERO (DONT_CARE_ZERO)
    ) u_entry (
      .clk_i         (clk_i),
      .async_rst_ni  (async_rst_ni),
      .set_i         (accept && (tail_q == ID_W'(i))),
      .set_wr_mask_i (disp_wr_mask_i),
      .set_rd_mask_i (disp_rd_mask_i),
      .wr_clr_i      (wr_clr_hit && (wr_clr_id_i == ID_W'(i))),
      .wr_clr_mask_i (wr_clr_mask_i),
      .rd_clr_i      (rd_clr_hit && (rd_clr_id_i == ID_W'(i))),
      .rd_clr_mask_i (rd_clr_mask_i),
      .done_i        (done_hit && (done_id_i == ID_W'(i))),
      .valid_o       (ent_valid[i]),
      .wr_mask_o     (ent_wr[i]),
      .rd_mask_o     (ent_rd[i])
    );
  end

  // Union of all registered reservations; same-cycle releases are deliberately not forwarded.
  always_comb begin
    pend_wr = '0;
    pend_rd = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      pend_wr = pend_wr | ent_wr[i];
      pend_rd = pend_rd | ent_rd[i];
    end
  end

  // Strict round-robin: a busy tail slot stalls dispatch even if other slots are free.
  always_comb begin
    full   = ent_valid[tail_q];
    hazard = (|((disp_wr_mask_i | disp_rd_mask_i) & pend_wr)) | (|(disp_wr_mask_i & pend_rd));
    accept = disp_valid_i & ~full & ~hazard;
    tail_d = accept ? tail_q + ID_W'(1) : tail_q;
    err_d  = err_q
           | (wr_clr_valid_i & ~ent_valid[wr_clr_id_i])
           | (rd_clr_valid_i & ~ent_valid[rd_clr_id_i])
           | (done_valid_i   & ~ent_valid[done_id_i]);
  end

  // Allocation pointer and sticky error flag.
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      tail_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tail_q <= tail_d;
      err_q  <= err_d;
    end
  end

  assign disp_ready_o = ~full & ~hazard;
  assign disp_id_o    = tail_q;
  assign pending_wr_o = pend_wr;
  assign pending_rd_o = pend_rd;
  assign busy_o       = |ent_valid;
  assign err_o        = err_q;

endmodule

// File: tb/tb_vproc_vreg_scoreboard.sv
// tb/tb_vproc_vreg_scoreboard.sv - randomized and directed bench against a slot-array reference model
module tb_vproc_vreg_scoreboard;
  import vproc_pkg::*;

  localparam int ID_W = 3;
  localparam int N    = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            disp_valid;
  logic            disp_ready;
  vreg_mask_t      disp_wr, disp_rd;
  logic [ID_W-1:0] disp_id;
  logic            wcv, rcv, dv;
  logic [ID_W-1:0] wcid, rcid, did;
  vreg_mask_t      wcm, rcm;
  vreg_mask_t      pend_wr, pend_rd;
  logic            busy, err;

  always #5 clk = ~clk;

  vproc_vreg_scoreboard #(.ID_W(ID_W), .DONT_CARE_ZERO(1'b0)) dut (
    .clk_i          (clk),
    .async_rst_ni   (rst_n),
    .disp_valid_i   (disp_valid),
    .disp_ready_o   (disp_ready),
    .disp_wr_mask_i (disp_wr),
    .disp_rd_mask_i (disp_rd),
    .disp_id_o      (disp_id),
    .wr_clr_valid_i (wcv),
    .wr_clr_id_i    (wcid),
    .wr_clr_mask_i  (wcm),
    .rd_clr_valid_i (rcv),
    .rd_clr_id_i    (rcid),
    .rd_clr_mask_i  (rcm),
    .done_valid_i   (dv),
    .done_id_i      (did),
    .pending_wr_o   (pend_wr),
    .pending_rd_o   (pend_rd),
    .busy_o         (busy),
    .err_o          (err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one record per in-flight instruction slot.
  bit          m_valid [N];
  logic [31:0] m_wr [N];
  logic [31:0] m_rd [N];
  int          m_tail;
  bit          m_err;
  bit          last_ready;

  function automatic logic [31:0] m_pend_wr();
    logic [31:0] r = 0;
    for (int i = 0; i < N; i++) if (m_valid[i]) r |= m_wr[i];
    return r;
  endfunction

  function automatic logic [31:0] m_pend_rd();
    logic [31:0] r = 0;
    for (int i = 0; i < N; i++) if (m_valid[i]) r |= m_rd[i];
    return r;
  endfunction

  function automatic bit m_ready(input logic [31:0] w, input logic [31:0] r);
    bit conflict;
    conflict = (((w | r) & m_pend_wr()) != 0) || ((w & m_pend_rd()) != 0);
    return !m_valid[m_tail] && !conflict;
  endfunction

  function automatic bit m_busy();
    for (int i = 0; i < N; i++) if (m_valid[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_wr[i] = 0; m_rd[i] = 0;
    end
    m_tail = 0;
    m_err  = 0;
  endtask

  task automatic drive_idle();
    disp_valid = 0; disp_wr = 0; disp_rd = 0;
    wcv = 0; wcid = 0; wcm = 0;
    rcv = 0; rcid = 0; rcm = 0;
    dv = 0; did = 0;
  endtask

  task automatic check_state();
    check_eq("pending_wr", pend_wr, m_pend_wr());
    check_eq("pending_rd", pend_rd, m_pend_rd());
    check_eq("busy", {31'b0, busy}, {31'b0, m_busy()});
    check_eq("err", {31'b0, err}, {31'b0, m_err});
  endtask

  // Reset asserted between edges so the asynchronous clear is observed before any clock.
  task automatic do_reset();
    drive_idle();
    rst_n = 0;
    #2;
    model_reset();
    check_state();
    check_eq("reset_ready", {31'b0, disp_ready}, 32'd1);
    check_eq("reset_id", {29'b0, disp_id}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  // One cycle: drive at posedge+1, check combinational outputs at negedge, update model at posedge.
  task automatic step(input bit vin, input logic [31:0] w, input logic [31:0] r,
                      input bit wc, input int wid, input logic [31:0] wm,
                      input bit rc, input int rid, input logic [31:0] rm,
                      input bit d, input int dnid);
    bit exp_ready, acc, wv, rv, dvv;
    disp_valid = vin; disp_wr = w; disp_rd = r;
    wcv = wc; wcid = wid[ID_W-1:0]; wcm = wm;
    rcv = rc; rcid = rid[ID_W-1:0]; rcm = rm;
    dv = d;   did = dnid[ID_W-1:0];
    @(negedge clk);
    exp_ready  = m_ready(w, r);
    last_ready = disp_ready;
    check_eq("ready", {31'b0, disp_ready}, {31'b0, exp_ready});
    check_eq("disp_id", {29'b0, disp_id}, m_tail);
    @(posedge clk);
    acc = vin && exp_ready;
    wv  = wc && m_valid[wid];
    rv  = rc && m_valid[rid];
    dvv = d && m_valid[dnid];
    if ((wc && !wv) || (rc && !rv) || (d && !dvv)) m_err = 1;
    if (wv) m_wr[wid] &= ~wm;
    if (rv) m_rd[rid] &= ~rm;
    if (dvv) begin
      m_valid[dnid] = 0; m_wr[dnid] = 0; m_rd[dnid] = 0;
    end
    if (acc) begin
      m_valid[m_tail] = 1; m_wr[m_tail] = w; m_rd[m_tail] = r;
      m_tail = (m_tail + 1) % N;
    end
    #1;
    check_state();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic dispatch(input logic [31:0] w, input logic [31:0] r);
    step(1, w, r, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic done(input int id);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, id);
  endtask

  function automatic logic [31:0] rand_mask();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'h1 << $urandom_range(0, 31);
      2:       return (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
      default: return $urandom & $urandom & $urandom;
    endcase
  endfunction

  function automatic int pick_id();
    int c;
    if ($urandom_range(0, 3) != 0) begin
      c = $urandom_range(0, N - 1);
      for (int k = 0; k < N; k++) if (m_valid[(c + k) % N]) return (c + k) % N;
    end
    return $urandom_range(0, N - 1);
  endfunction

  initial begin
    logic [31:0] pw_before, pr_before;
    drive_idle();
    model_reset();
    #1;
    do_reset();

    // Reset then dispatch
    dispatch(32'h4, 32'h3);
    check_eq("first_ready", {31'b0, last_ready}, 32'd1);
    check_eq("first_pend_wr", pend_wr, 32'h4);
    check_eq("first_pend_rd", pend_rd, 32'h3);

    // RAW stall, release one cycle after done
    dispatch(32'h0, 32'h4);
    check_eq("raw_stall", {31'b0, last_ready}, 32'd0);
    step(1, 0, 32'h4, 0, 0, 0, 0, 0, 0, 1, 0);
    check_eq("raw_same_cycle", {31'b0, last_ready}, 32'd0);
    dispatch(32'h0, 32'h4);
    check_eq("raw_release", {31'b0, last_ready}, 32'd1);
    check_eq("raw_next_id", {29'b0, disp_id}, 32'd2);

    // WAR and WAW
    do_reset();
    dispatch(32'h0, 32'h10);
    dispatch(32'h10, 32'h0);
    check_eq("war_stall", {31'b0, last_ready}, 32'd0);
    step(1, 32'h10, 0, 0, 0, 0, 1, 0, 32'h10, 0, 0);
    dispatch(32'h10, 32'h0);
    check_eq("war_release", {31'b0, last_ready}, 32'd1);
    do_reset();
    dispatch(32'hFF00, 32'h0);
    dispatch(32'h0100, 32'h0);
    check_eq("waw_stall", {31'b0, last_ready}, 32'd0);
    step(1, 32'h0100, 0, 1, 0, 32'h0100, 0, 0, 0, 0, 0);
    dispatch(32'h0100, 32'h0);
    check_eq("waw_release", {31'b0, last_ready}, 32'd1);

    // Full and wrap
    do_reset();
    for (int i = 0; i < N; i++) begin
      dispatch(32'h1 << i, 32'h0);
      check_eq("fill_ready", {31'b0, last_ready}, 32'd1);
    end
    dispatch(32'h0, 32'h0);
    check_eq("full_stall", {31'b0, last_ready}, 32'd0);
    done(3);
    dispatch(32'h0, 32'h0);
    check_eq("tail_busy_stall", {31'b0, last_ready}, 32'd0);
    done(0);
    dispatch(32'h0, 32'h0);
    check_eq("wrap_ready", {31'b0, last_ready}, 32'd1);
    check_eq("wrap_id_next", {29'b0, disp_id}, 32'd1);

    // Error on invalid done, state otherwise untouched
    pw_before = pend_wr;
    pr_before = pend_rd;
    done(3);
    check_eq("err_set", {31'b0, err}, 32'd1);
    check_eq("err_pend_wr", pend_wr, pw_before);
    check_eq("err_pend_rd", pend_rd, pr_before);
    idle();
    check_eq("err_sticky", {31'b0, err}, 32'd1);

    // Simultaneous events
    do_reset();
    dispatch(32'h1, 32'h0);
    dispatch(32'h2, 32'h0);
    dispatch(32'h4, 32'h0);
    step(0, 0, 0, 1, 2, 32'h1, 1, 2, 32'h4, 1, 2);
    check_eq("clr_done_freed", pend_wr, 32'h3);
    step(1, 32'h8, 32'h0, 0, 0, 0, 0, 0, 0, 1, 0);
    check_eq("acc_done_wr", pend_wr, 32'hA);
    check_eq("acc_done_err", {31'b0, err}, 32'd0);
    step(1, 32'h10, 32'h0, 0, 0, 0, 0, 0, 0, 1, 4);
    check_eq("done_on_accept_err", {31'b0, err}, 32'd1);
    check_eq("done_on_accept_kept", pend_wr, 32'h1A);

    // Randomized traffic with a mid-run reset
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      step($urandom_range(0, 9) < 7, rand_mask(), rand_mask(),
           $urandom_range(0, 3) == 0, pick_id(), rand_mask(),
           $urandom_range(0, 3) == 0, pick_id(), rand_mask(),
           $urandom_range(0, 9) < 3, pick_id());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
